sig_rx_parse: RTL
=================

# sig_rx_parse

Receive-side SIGNAL field parser for the OFDM link. It consumes the decoded SIGNAL bit stream serially and recovers the 32-bit SIGNAL word that the transmitter built from `sig_di_type` and `sig_di_len`. It checks parity, tail and length, then presents the frame type and payload length to the payload demodulator with a one-cycle valid or error strobe. It sits between the SIGNAL-symbol decoder and the payload receive chain.

## Interface
- `MAX_LEN`, default 16'd4095: largest legal payload length; larger values raise a length error.
- `TIMEOUT`, default 255: number of consecutive idle cycles (`di_vld`=0) in COLLECT that aborts the frame.
- `sig_clk_c`  in  1  processing clock.
- `sig_rst`  in  1  reset, active-high, synchronous to `sig_clk_c`.
- `new_frame`  in  1  one-cycle pulse from the frame synchroniser marking the start of a SIGNAL field.
- `di_bit`  in  1  decoded SIGNAL bit, in transmit order (bit 0 first).
- `di_vld`  in  1  qualifies `di_bit`.
- `sig_do_hdr`  out  8  SIGNAL bits 0..7 (header/rate field), bit k = SIGNAL bit k.
- `sig_do_type`  out  4  SIGNAL bits 8..11, `sig_do_type[k]` = bit 8+k.
- `sig_do_len`  out  16  SIGNAL bits 12..27, `sig_do_len[k]` = bit 12+k.
- `sig_do_vld`  out  1  one-cycle pulse: a good SIGNAL word is on the fields.
- `sig_do_err`  out  1  one-cycle pulse: the frame was rejected.
- `sig_err_code`  out  4  flags, valid with `sig_do_err`: [0] parity, [1] tail, [2] length, [3] timeout.
- `busy`  out  1  high in COLLECT and CHECK.

## Operation
- SIGNAL word layout:
  - bits 0..27: fields as above.
  - bit 28: even parity, so the XOR of bits 0..28 equals 0.
  - bits 29..31: tail, which must be 000.
- States: IDLE, COLLECT, CHECK.
- IDLE: `di_vld` is ignored. `new_frame` moves to COLLECT, clears the bit index (0..31) and the gap counter.
- COLLECT:
  - Each cycle with `di_vld`=1 stores `di_bit` at the current index, increments the index and clears the gap counter.
  - When bit 31 is stored, move to CHECK.
  - Each cycle with `di_vld`=0 increments the gap counter. When the counter reaches `TIMEOUT`:
    - pulse `sig_do_err` with `sig_err_code`=4'b1000;
    - leave the field outputs unchanged;
    - return to IDLE.
- CHECK (exactly one cycle):
  - Evaluate parity, tail and length. The length flag is set when `len`==0 or `len` > `MAX_LEN`.
  - Register `sig_do_hdr`, `sig_do_type` and `sig_do_len` from the word whether or not an error is found.
  - No flag set: pulse `sig_do_vld`.
  - Any flag set: pulse `sig_do_err` with all applicable flags set; several flags may be set together.
  - Then go to IDLE, or to COLLECT if `new_frame` is high in CHECK.
- `new_frame` in COLLECT: restart at index 0 and discard the partial word, with no error pulse. A `di_bit` presented in the same cycle is discarded.
- `new_frame` with `di_vld` in IDLE: the bit is not captured; the first captured bit comes on a later cycle.
- `sig_do_vld` and `sig_do_err` are never high in the same cycle.
- `sig_err_code` holds its last value between error pulses.

## Timing
- Reset (`sig_rst`=1 at a clock edge):
  - state goes to IDLE;
  - index, gap counter and the stored word are cleared;
  - all outputs are 0;
  - this applies mid-frame: a partial frame is dropped with no strobe.
- Latency: bit 31 is sampled at edge N. The state is CHECK during cycle N+1. At edge N+1 the fields and strobe are registered, and `sig_do_vld`/`sig_do_err` are high during cycle N+2 only.
- Field outputs stay stable from that edge until the next CHECK.
- `busy` rises in the cycle after `new_frame` is sampled and falls when IDLE is entered.
- Timeout strobe: high in the cycle after the edge at which the gap counter reaches `TIMEOUT`.
- Input bits may arrive every cycle back-to-back or with arbitrary gaps below `TIMEOUT`.

## Test plan
- Good frame: `new_frame`, then 32 bits with hdr=0, type=4'b0101, len=16'd100, parity bit=1, tail 000, sent at one bit every 3 cycles. Required: `sig_do_vld` pulses once; `sig_do_type`=5; `sig_do_len`=100; `sig_do_err` stays 0.
- Parity error: same frame with the parity bit set to 0. Required: `sig_do_err` pulses once, `sig_err_code`=4'b0001, fields still show type 5 / len 100, `sig_do_vld` stays 0.
- Tail and length: len=0, tail=3'b100, parity correct over bits 0..28. Required: `sig_err_code`=4'b0110.
- Timeout: `new_frame`, 10 bits, then `di_vld` low for 255 cycles. Required: `sig_do_err` with code 4'b1000, fields unchanged from the previous frame, `busy` drops.
- Restart and reset: `new_frame` again after 20 bits, then a full good frame of type=4'b0011, len=16'd2000. Required: exactly one `sig_do_vld` with those values. Then assert `sig_rst` for one cycle after 15 bits of another frame. Required: all outputs 0 and no strobe.
- Back-to-back: two good frames sent with `di_vld` continuously high, with `new_frame` asserted during the CHECK cycle of the first. Required: two `sig_do_vld` pulses, separated by 33 cycles.

Source files
------------

// File: rtl/sig_rx_parse.sv
// sig_rx_parse: serial receiver for the 32-bit SIGNAL word. It collects the
// bits, checks parity, tail and length, and then presents the header, type and
// length fields together with a one-cycle valid or error strobe.
module sig_rx_parse #(
  parameter logic [15:0] MAX_LEN = 16'd4095,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        sig_clk_c,
  input  logic        sig_rst,
  input  logic        new_frame,
  input  logic        di_bit,
  input  logic        di_vld,
  output logic [7:0]  sig_do_hdr,
  output logic [3:0]  sig_do_type,
  output logic [15:0] sig_do_len,
  output logic        sig_do_vld,
  output logic        sig_do_err,
  output logic [3:0]  sig_err_code,
  output logic        busy
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned GAP_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [GAP_W-1:0]    gap, gap_nxt, gap_inc;
  logic [WORD_W-1:0]   word, word_nxt;
  logic [7:0]          hdr_nxt;
  logic [3:0]          type_nxt;
  logic [15:0]         len_nxt;
  logic                vld_nxt, err_nxt, busy_nxt;
  logic [3:0]          code_nxt;

  logic                par_err, tail_err, len_err;
  logic [15:0]         word_len;

  // Word checks, evaluated on the collected word during CHECK
  assign word_len = word[27:12];
  assign par_err  = ^word[28:0];
  assign tail_err = |word[31:29];
  assign len_err  = (word_len == 16'd0) || (word_len > MAX_LEN);

  // State and datapath register with synchronous reset
  always_ff @(posedge sig_clk_c) begin
    if (sig_rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      gap          <= '0;
      word         <= '0;
      sig_do_hdr   <= '0;
      sig_do_type  <= '0;
      sig_do_len   <= '0;
      sig_do_vld   <= 1'b0;
      sig_do_err   <= 1'b0;
      sig_err_code <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      gap          <= gap_nxt;
      word         <= word_nxt;
      sig_do_hdr   <= hdr_nxt;
      sig_do_type  <= type_nxt;
      sig_do_len   <= len_nxt;
      sig_do_vld   <= vld_nxt;
      sig_do_err   <= err_nxt;
      sig_err_code <= code_nxt;
      busy         <= busy_nxt;
    end
  end

  // Next-state, bit capture, gap timing and result strobes
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    gap_nxt   = gap;
    gap_inc   = gap + GAP_W'(1);
    word_nxt  = word;
    hdr_nxt   = sig_do_hdr;
    type_nxt  = sig_do_type;
    len_nxt   = sig_do_len;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = sig_err_code;

    case (state)
      S_IDLE: begin
        if (new_frame) begin
          state_nxt = S_COLLECT;
          idx_nxt   = '0;
          gap_nxt   = '0;
        end
      end

      S_COLLECT: begin
        if (new_frame) begin
          // restart drops the partial word and any bit on this cycle
          idx_nxt = '0;
          gap_nxt = '0;
        end else if (di_vld) begin
          word_nxt[idx] = di_bit;
          idx_nxt       = idx + IDX_W'(1);
          gap_nxt       = '0;
          if (idx == IDX_W'(WORD_W - 1)) begin
            state_nxt = S_CHECK;
          end
        end else begin
          gap_nxt = gap_inc;
          if (gap_inc == GAP_W'(TIMEOUT)) begin
            err_nxt   = 1'b1;
            code_nxt  = 4'b1000;
            state_nxt = S_IDLE;
          end
        end
      end

      S_CHECK: begin
        hdr_nxt  = word[7:0];
        type_nxt = word[11:8];
        len_nxt  = word_len;
        if (par_err || tail_err || len_err) begin
          err_nxt  = 1'b1;
          code_nxt = {1'b0, len_err, tail_err, par_err};
        end else begin
          vld_nxt = 1'b1;
        end
        idx_nxt   = '0;
        gap_nxt   = '0;
        state_nxt = new_frame ? S_COLLECT : S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule
